// File: rtl/nco_pkg.sv
// Shared NCO definitions: tuning-word width, sweep state encoding and the
// latched sweep configuration record.
package nco_pkg;

  localparam int STEP_SIZE   = 16;
  localparam int COUNT_WIDTH = 12;
  localparam int DWELL_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } sweep_state_t;

  typedef struct packed {
    logic [STEP_SIZE-1:0]   start_step;
    logic [STEP_SIZE-1:0]   delta_step;
    logic [COUNT_WIDTH-1:0] num_steps;
    logic [DWELL_WIDTH-1:0] dwell;
    logic                   repeat_en;
  } sweep_cfg_t;

endpackage

// File: rtl/nco_dwell_cnt.sv
// Per-segment dwell counter; raises last on the final cycle of a segment and
// wraps to zero so the next segment starts counting immediately.
module nco_dwell_cnt #(
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic [DWELL_WIDTH-1:0] dwell_eff,
  output logic                   last
);

  logic [DWELL_WIDTH-1:0] count;

  assign last = (count == dwell_eff - DWELL_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst || clear)
      count <= '0;
    else if (last)
      count <= '0;
    else
      count <= count + DWELL_WIDTH'(1);
  end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Stepped linear frequency sweep sequencer driving the NCO tuning word, with
// a one-cycle phase-reset prime at sweep start and optional continuous repeat.
module nco_sweep_ctrl #(
  parameter int STEP_SIZE   = nco_pkg::STEP_SIZE,
  parameter int COUNT_WIDTH = nco_pkg::COUNT_WIDTH,
  parameter int DWELL_WIDTH = nco_pkg::DWELL_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   repeat_en,
  input  logic [STEP_SIZE-1:0]   start_step,
  input  logic [STEP_SIZE-1:0]   delta_step,
  input  logic [COUNT_WIDTH-1:0] num_steps,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic [STEP_SIZE-1:0]   step,
  output logic                   nco_rst,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] seg_idx
);

  import nco_pkg::*;

  sweep_state_t           state;
  sweep_cfg_t             cfg;
  logic [DWELL_WIDTH-1:0] dwell_eff;
  logic [COUNT_WIDTH-1:0] num_eff;
  logic                   dwell_last;
  logic                   seg_last;

  // Zero-length dwell or segment count behaves as one.
  assign dwell_eff = (cfg.dwell == '0) ? DWELL_WIDTH'(1) : cfg.dwell;
  assign num_eff   = (cfg.num_steps == '0) ? COUNT_WIDTH'(1) : cfg.num_steps;
  assign seg_last  = (seg_idx == num_eff - COUNT_WIDTH'(1));

  nco_dwell_cnt #(
    .DWELL_WIDTH(DWELL_WIDTH)
  ) u_dwell_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear     (state != RUN),
    .dwell_eff (dwell_eff),
    .last      (dwell_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cfg     <= '0;
      step    <= '0;
      nco_rst <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      seg_idx <= '0;
    end else begin
      done    <= 1'b0;
      nco_rst <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            cfg <= '{start_step: start_step, delta_step: delta_step,
                     num_steps: num_steps, dwell: dwell, repeat_en: repeat_en};
            state   <= PRIME;
            nco_rst <= 1'b1;
            busy    <= 1'b1;
            step    <= start_step;
            seg_idx <= '0;
          end
        end
        PRIME: begin
          if (abort) begin
            state   <= IDLE;
            step    <= '0;
            busy    <= 1'b0;
            seg_idx <= '0;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state   <= IDLE;
            step    <= '0;
            busy    <= 1'b0;
            seg_idx <= '0;
          end else if (dwell_last) begin
            if (!seg_last) begin
              step    <= step + cfg.delta_step;
              seg_idx <= seg_idx + COUNT_WIDTH'(1);
            end else if (cfg.repeat_en) begin
              // Repeat restarts the word without re-priming, keeping phase continuous.
              step    <= cfg.start_step;
              seg_idx <= '0;
            end else begin
              state   <= IDLE;
              done    <= 1'b1;
              busy    <= 1'b0;
              step    <= '0;
              seg_idx <= '0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          step    <= '0;
          busy    <= 1'b0;
          seg_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: directed and random sweeps compared
// cycle by cycle against an expected trace built from the sweep rules.
module tb_nco_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        repeat_en = 1'b0;
  logic [15:0] start_step = '0;
  logic [15:0] delta_step = '0;
  logic [11:0] num_steps = '0;
  logic [15:0] dwell = '0;
  logic [15:0] step;
  logic        nco_rst;
  logic        busy;
  logic        done;
  logic [11:0] seg_idx;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] step;
    logic        nco;
    logic        busy;
    logic        done;
    logic [11:0] seg;
  } exp_t;

  exp_t trace[$];

  nco_sweep_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .repeat_en  (repeat_en),
    .start_step (start_step),
    .delta_step (delta_step),
    .num_steps  (num_steps),
    .dwell      (dwell),
    .step       (step),
    .nco_rst    (nco_rst),
    .busy       (busy),
    .done       (done),
    .seg_idx    (seg_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(input string tag, input exp_t e);
    checkField({tag, ".step"},    32'(step),    32'(e.step));
    checkField({tag, ".nco_rst"}, 32'(nco_rst), 32'(e.nco));
    checkField({tag, ".busy"},    32'(busy),    32'(e.busy));
    checkField({tag, ".done"},    32'(done),    32'(e.done));
    checkField({tag, ".seg_idx"}, 32'(seg_idx), 32'(e.seg));
  endtask

  function automatic exp_t idleExp();
    exp_t e;
    e.step = '0; e.nco = 1'b0; e.busy = 1'b0; e.done = 1'b0; e.seg = '0;
    return e;
  endfunction

  // Expected per-cycle outputs from the PRIME cycle onward: segment k holds
  // start + k*delta for dwell cycles, the very first segment one extra cycle.
  task automatic buildTrace(input logic [15:0] s, input logic [15:0] d, input int n,
                            input int w, input bit r, input int periods);
    int ne, we, len;
    exp_t e;
    ne = (n == 0) ? 1 : n;
    we = (w == 0) ? 1 : w;
    trace.delete();
    for (int p = 0; p < periods; p++) begin
      for (int k = 0; k < ne; k++) begin
        len = (p == 0 && k == 0) ? we + 1 : we;
        for (int j = 0; j < len; j++) begin
          e.step = s + d * k[15:0];
          e.nco  = (p == 0 && k == 0 && j == 0);
          e.busy = 1'b1;
          e.done = 1'b0;
          e.seg  = k[11:0];
          trace.push_back(e);
        end
      end
    end
    if (!r) begin
      e = idleExp();
      e.done = 1'b1;
      trace.push_back(e);
    end
  endtask

  // Drives a configuration with a start pulse; returns sampling the PRIME cycle.
  task automatic applyStimulus(input logic [15:0] s, input logic [15:0] d, input int n,
                               input int w, input bit r, input int periods);
    start_step = s;
    delta_step = d;
    num_steps  = n[11:0];
    dwell      = w[15:0];
    repeat_en  = r;
    start      = 1'b1;
    buildTrace(s, d, n, w, r, periods);
    tick();
    start = 1'b0;
  endtask

  task automatic followTrace(input string tag, input int poke_at, input int abort_at,
                             input int rst_at);
    for (int i = 0; i < trace.size(); i++) begin
      if (i > 0) tick();
      checkOutput($sformatf("%s[%0d]", tag, i), trace[i]);
      if (i == poke_at) begin
        start      = 1'b1;
        start_step = 16'($urandom);
        delta_step = 16'($urandom);
        num_steps  = 12'($urandom_range(1, 7));
        dwell      = 16'($urandom_range(1, 7));
        repeat_en  = 1'($urandom);
      end else if (i == poke_at + 1) begin
        start = 1'b0;
      end
      if (i == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput({tag, ".abort"}, idleExp());
        return;
      end
      if (i == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput({tag, ".rst"}, idleExp());
        return;
      end
    end
  endtask

  initial begin
    tick();
    tick();
    checkOutput("reset", idleExp());
    rst = 1'b0;
    tick();
    checkOutput("idle", idleExp());

    applyStimulus(16'h0100, 16'h0040, 4, 3, 1'b0, 1);
    followTrace("basic", -1, -1, -1);

    applyStimulus(16'hFFC0, 16'h0080, 2, 1, 1'b0, 1);
    followTrace("wrap", -1, -1, -1);

    applyStimulus(16'h0100, 16'hFFC0, 3, 2, 1'b0, 1);
    followTrace("negdelta", -1, -1, -1);

    applyStimulus(16'h1234, 16'h0001, 0, 0, 1'b0, 1);
    followTrace("degen", -1, -1, -1);
    applyStimulus(16'h4321, 16'h0002, 0, 0, 1'b0, 1);
    followTrace("degen2", -1, -1, -1);

    applyStimulus(16'h0010, 16'h0010, 2, 2, 1'b1, 3);
    followTrace("repeat", -1, trace.size() - 1, -1);

    applyStimulus(16'h0010, 16'h0010, 2, 2, 1'b1, 1);
    followTrace("abortseg1", -1, 3, -1);

    applyStimulus(16'h0100, 16'h0040, 4, 3, 1'b0, 1);
    followTrace("midrst", -1, -1, 6);

    applyStimulus(16'h0100, 16'h0040, 4, 3, 1'b0, 1);
    followTrace("ignstart", 5, -1, -1);

    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checkOutput("startabort", idleExp());
    tick();
    checkOutput("startabort2", idleExp());

    for (int t = 0; t < 8; t++) begin
      applyStimulus(16'($urandom), 16'($urandom), $urandom_range(0, 5),
                    $urandom_range(0, 4), 1'b0, 1);
      followTrace($sformatf("rand%0d", t), -1, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
- Sequencer that drives the NCO `step` (tuning word) input to produce a stepped linear frequency sweep (chirp).
- Latches a sweep configuration on a start pulse and pulses an NCO phase reset at sweep start.
- Holds each step value for a programmable dwell, then adds a signed increment.
- Finishes after N segments, or repeats continuously; sits between the control/register layer and the NCO instance.

Parameters:
- STEP_SIZE, 16, width of the tuning word; must equal the NCO STEP_SIZE.
- COUNT_WIDTH, 12, width of the segment count and segment index.
- DWELL_WIDTH, 16, width of the dwell length (clock cycles per segment).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  sweep request pulse; sampled only in IDLE.
- abort  input  1  terminate the sweep immediately.
- repeat_en  input  1  1 = restart the sweep after the last segment; latched at start.
- start_step  input  STEP_SIZE  first tuning word; latched at start.
- delta_step  input  STEP_SIZE  signed two's-complement increment per segment; latched at start.
- num_steps  input  COUNT_WIDTH  number of segments; 0 is treated as 1; latched at start.
- dwell  input  DWELL_WIDTH  cycles per segment; 0 is treated as 1; latched at start.
- step  output  STEP_SIZE  tuning word to the NCO (registered).
- nco_rst  output  1  NCO phase-accumulator reset (registered).
- busy  output  1  high while a sweep is in progress.
- done  output  1  single-cycle pulse on normal sweep completion.
- seg_idx  output  COUNT_WIDTH  index of the current segment.

Behaviour:
- Reset: on any rst edge all registers clear next cycle.
  - state=IDLE; step=0, nco_rst=0, busy=0, done=0, seg_idx=0.
  - rst has priority over every other input, including mid-sweep.
- States are IDLE, PRIME and RUN; all outputs are registered.
- IDLE, start=1, abort=0 (cycle T):
  - Latch the configuration.
  - At T+1: state=PRIME, nco_rst=1, busy=1, step=start_step, seg_idx=0.
- IDLE with start=1 and abort=1: abort wins; start is ignored.
- start while busy: ignored; the latched configuration is unaffected by input changes.
- PRIME: lasts exactly one cycle.
  - At T+2: state=RUN, nco_rst=0, and the dwell counter begins at 0.
  - step=start_step therefore holds for dwell+1 cycles in total (the PRIME cycle plus dwell).
- RUN, mid-segment: the dwell counter increments each cycle.
- RUN, on the last dwell cycle of a segment (counter = dwell_eff-1):
  - Not the last segment (seg_idx < num_eff-1): next cycle step = step+delta_step, seg_idx+1, counter=0.
  - Last segment with repeat_en=1: next cycle step=start_step, seg_idx=0, counter=0; no nco_rst and no PRIME (phase stays continuous).
  - Last segment with repeat_en=0: next cycle state=IDLE, done=1 for one cycle, busy=0, step=0, seg_idx=0.
- Each segment after the first holds its step for exactly dwell_eff cycles.
- Arithmetic: step+delta_step is modulo 2^STEP_SIZE.
  - Wrap is silent, with no saturation.
  - A negative delta is the two's-complement value.
- abort in PRIME or RUN:
  - Next cycle state=IDLE, step=0, nco_rst=0, busy=0, seg_idx=0.
  - done stays 0.
- abort in IDLE: no effect.
- done: never high together with busy, except the degenerate case below.
  - A new start is accepted in the same cycle done is high (state is already IDLE).
- Non-repeat sweep duration: busy is high for 1 + num_eff*dwell_eff cycles.

Decomposition:
- Shared package nco_pkg:
  - STEP_SIZE default constant shared with the NCO.
  - Sweep state enumeration (IDLE, PRIME, RUN).
  - A sweep-config record type: start_step, delta_step, num_steps, dwell, repeat_en.
- One natural sub-module, nco_dwell_cnt: a loadable dwell counter.
  - Inputs: clear and dwell_eff.
  - Output: a `last` flag when count = dwell_eff-1.
  - The FSM and step arithmetic stay in nco_sweep_ctrl.
- System top-level: nco_sweep_ctrl.step feeds NCO.step, and NCO.rst = rst OR nco_rst.

Test Plan:
- Basic sweep: start_step=0x0100, delta=0x0040, num=4, dwell=3, repeat=0.
  - Required: nco_rst high 1 cycle, then step sequence 0x0100×4 cycles, then 0x0140×3, 0x0180×3, 0x01C0×3.
  - busy is high 13 cycles, then done pulses once with step=0.
- Wrap and negative delta, part 1: start=0xFFC0, delta=0x0080, num=2, dwell=1.
  - Required: step = 0xFFC0, 0xFFC0, 0x0040, then done.
- Wrap and negative delta, part 2: start=0x0100, delta=0xFFC0, num=3, dwell=2.
  - Required: step = 0x0100×3, then 0x00C0×2, then 0x0080×2.
- Degenerate values: num=0, dwell=0.
  - Required: behaves as num=1, dwell=1; busy high 2 cycles, then done.
  - A start in the done cycle launches a second sweep.
- Repeat and abort: repeat=1, start=0x0010, delta=0x0010, num=2, dwell=2.
  - Required: step repeats 0x0010, 0x0020 indefinitely, with no nco_rst after the first and no done.
  - abort in segment 1: next cycle busy=0, step=0, done=0.
- Reset and ignored start: rst asserted mid-RUN clears all outputs next cycle.
  - A start pulse while busy leaves the step sequence unchanged.
  - Simultaneous start+abort in IDLE leaves busy=0.
